pipeline_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the vector ASIP 5-register pipeline: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Drives one enable and one flush per pipeline register. The stage registers stay the team's common enabled-register instances; flush is applied by forcing their data_in to 0 while enabled.
- Resolves debug halt, taken branches, multi-cycle vector ops in EX, and load-use hazards into a single per-cycle enable/flush vector.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipeline_stall_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared indices, state type and enable/flush patterns for the pipeline stall sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Bit positions of the pipeline registers in stage_en / stage_flush.
    localparam int IDX_PC    = 0;
    localparam int IDX_IFID  = 1;
    localparam int IDX_IDEX  = 2;
    localparam int IDX_EXMEM = 3;
    localparam int IDX_MEMWB = 4;
    localparam int NREG      = 5;

    typedef enum logic {
        RUN      = 1'b0,
        VEC_WAIT = 1'b1
    } pctrl_state_t;

    // Enable patterns (bit 0 = PC ... bit 4 = MEM/WB).
    localparam logic [NREG-1:0] EN_ALL      = 5'b11111;
    localparam logic [NREG-1:0] EN_NONE     = 5'b00000;
    localparam logic [NREG-1:0] EN_HOLD_VEC = 5'b11000;
    localparam logic [NREG-1:0] EN_HOLD_LU  = 5'b11100;

    // Flush patterns; a flush bit only takes effect when its enable bit is set.
    localparam logic [NREG-1:0] FL_NONE     = 5'b00000;
    localparam logic [NREG-1:0] FL_ALL      = 5'b11111;
    localparam logic [NREG-1:0] FL_BRANCH   = 5'b00110;
    localparam logic [NREG-1:0] FL_VEC      = 5'b01000;
    localparam logic [NREG-1:0] FL_LU       = 5'b00100;

endpackage

// File: rtl/pipeline_stall_ctrl.sv
// Purpose: resolves halt / taken branch / multi-cycle vector op / load-use into per-register enable+flush, counts stall cycles.
// Latency: stage_en/stage_flush are combinational (act on the coming edge); busy and stall_cycles are registered.
// Backpressure: halt freezes everything; a vector op holds PC..ID/EX for VEC_LAT-1 cycles, load-use holds PC/IF-ID for one cycle.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   halt                  debug freeze (highest priority)
//   branch_taken          EX resolved a taken branch
//   ex_vec_start          first EX cycle of a multi-cycle vector op
//   id_load_use           ID depends on the load in EX
//   stage_en/stage_flush  per-register enable and bubble-insert (bit 0 = PC)
//   busy                  vector op in progress
//   stall_cycles          saturating count of non-halt cycles with PC held
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int VEC_LAT = 4,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              branch_taken,
    input  logic              ex_vec_start,
    input  logic              id_load_use,
    output logic [NREG-1:0]   stage_en,
    output logic [NREG-1:0]   stage_flush,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int               CNT_W     = $clog2(VEC_LAT);
    // The start cycle already counts as one EX cycle of the op.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(VEC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    pctrl_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_nxt;
    logic             stall_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        busy_nxt    = busy;
        stage_en    = EN_ALL;
        stage_flush = FL_NONE;

        if (reset) begin
            // Clear every stage register while reset is held.
            stage_en    = EN_ALL;
            stage_flush = FL_ALL;
        end else if (halt) begin
            // Full freeze: no register moves and no sequencer state advances.
            stage_en    = EN_NONE;
            stage_flush = FL_NONE;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        stage_flush = FL_BRANCH;
                    end else if (ex_vec_start) begin
                        stage_en    = EN_HOLD_VEC;
                        stage_flush = FL_VEC;
                        state_nxt   = VEC_WAIT;
                        cnt_nxt     = CNT_START;
                        busy_nxt    = 1'b1;
                    end else if (id_load_use) begin
                        stage_en    = EN_HOLD_LU;
                        stage_flush = FL_LU;
                    end
                end
                VEC_WAIT: begin
                    // Requests are ignored here; upstream is held so they re-present after release.
                    if (cnt > CNT_ONE) begin
                        stage_en    = EN_HOLD_VEC;
                        stage_flush = FL_VEC;
                        cnt_nxt     = cnt - CNT_ONE;
                    end else begin
                        state_nxt = RUN;
                        busy_nxt  = 1'b0;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Halt cycles are deliberately not counted.
    assign stall_inc = !reset && !halt && !stage_en[IDX_PC];

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_inc && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Purpose: self-checking bench for pipeline_stall_ctrl (VEC_LAT=4, PERF_W=16).
// Latency: outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_pipeline_stall_ctrl;

    localparam int VEC_LAT = 4;
    localparam int PERF_W  = 16;
    localparam int SAT     = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              halt;
    logic              branch_taken;
    logic              ex_vec_start;
    logic              id_load_use;
    logic [4:0]        stage_en;
    logic [4:0]        stage_flush;
    logic              busy;
    logic [PERF_W-1:0] stall_cycles;

    int tests  = 0;
    int errors = 0;

    pipeline_stall_ctrl #(.VEC_LAT(VEC_LAT), .PERF_W(PERF_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .halt         (halt),
        .branch_taken (branch_taken),
        .ex_vec_start (ex_vec_start),
        .id_load_use  (id_load_use),
        .stage_en     (stage_en),
        .stage_flush  (stage_flush),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A vector op is tracked as "EX cycles already served"; the op's last
    // EX cycle (served == VEC_LAT-1 on entry) releases the pipeline.
    bit m_valid  = 0;
    bit m_in_op  = 0;
    int m_served = 0;
    int m_stall  = 0;

    always @(negedge clk) begin
        logic [4:0] e_en;
        logic [4:0] e_fl;
        e_en = 5'b11111;
        e_fl = 5'b00000;
        if (m_valid) begin
            chk("busy_model",  {31'd0, busy}, {31'd0, m_in_op});
            chk("stall_model", {16'd0, stall_cycles}, m_stall);
        end
        if (reset) begin
            e_fl     = 5'b11111;
            m_in_op  = 0;
            m_served = 0;
            m_stall  = 0;
            m_valid  = 1;
        end else if (halt) begin
            e_en = 5'b00000;
        end else if (m_in_op) begin
            if (branch_taken || ex_vec_start) begin
                tests++;
                errors++;
                $display("FAIL stim_in_vec: branch/vec request during vector op at %0t", $time);
            end
            if (m_served == VEC_LAT - 1) begin
                m_in_op = 0;
            end else begin
                e_en = 5'b11000;
                e_fl = 5'b01000;
                m_served++;
            end
        end else if (branch_taken) begin
            e_fl = 5'b00110;
        end else if (ex_vec_start) begin
            e_en     = 5'b11000;
            e_fl     = 5'b01000;
            m_in_op  = 1;
            m_served = 1;
        end else if (id_load_use) begin
            e_en = 5'b11100;
            e_fl = 5'b00100;
        end
        if (!reset && !halt && !e_en[0] && m_stall < SAT) m_stall++;
        if (m_valid) begin
            chk("en_model", {27'd0, stage_en},    {27'd0, e_en});
            chk("fl_model", {27'd0, stage_flush}, {27'd0, e_fl});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic r, input logic h, input logic b, input logic v, input logic l);
        reset = r; halt = h; branch_taken = b; ex_vec_start = v; id_load_use = l;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_en", {27'd0, stage_en},    32'h1F);
        chk("reset_fl", {27'd0, stage_flush}, 32'h1F);

        // Idle
        next_cyc(); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle_en",    {27'd0, stage_en},    32'h1F);
        chk("idle_fl",    {27'd0, stage_flush}, 32'h00);
        chk("idle_stall", {16'd0, stall_cycles}, 32'd0);
        chk("idle_busy",  {31'd0, busy}, 32'd0);

        // Load-use, one cycle
        next_cyc(); drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("lu_en", {27'd0, stage_en},    32'h1C);
        chk("lu_fl", {27'd0, stage_flush}, 32'h04);
        next_cyc(); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_after_en",    {27'd0, stage_en}, 32'h1F);
        chk("lu_after_stall", {16'd0, stall_cycles}, 32'd1);

        // Vector op: 3 hold cycles, release on the 4th
        next_cyc(); drive(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("vec_c1_en",   {27'd0, stage_en},    32'h18);
        chk("vec_c1_fl",   {27'd0, stage_flush}, 32'h08);
        chk("vec_c1_busy", {31'd0, busy}, 32'd0);
        next_cyc(); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("vec_c2_en",   {27'd0, stage_en}, 32'h18);
        chk("vec_c2_busy", {31'd0, busy}, 32'd1);
        next_cyc();
        @(negedge clk);
        chk("vec_c3_en",   {27'd0, stage_en}, 32'h18);
        next_cyc();
        @(negedge clk);
        chk("vec_c4_en",   {27'd0, stage_en},    32'h1F);
        chk("vec_c4_fl",   {27'd0, stage_flush}, 32'h00);
        chk("vec_c4_busy", {31'd0, busy}, 32'd1);
        next_cyc();
        @(negedge clk);
        chk("vec_c5_busy",  {31'd0, busy}, 32'd0);
        chk("vec_c5_stall", {16'd0, stall_cycles}, 32'd4);

        // All three requests together: branch wins
        next_cyc(); drive(0, 0, 1, 1, 1);
        @(negedge clk);
        chk("prio_en", {27'd0, stage_en},    32'h1F);
        chk("prio_fl", {27'd0, stage_flush}, 32'h06);
        next_cyc(); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("prio_busy", {31'd0, busy}, 32'd0);
        chk("prio_en2",  {27'd0, stage_en}, 32'h1F);

        // Halt for 2 cycles at cnt=2 inside a vector op
        next_cyc(); drive(0, 0, 0, 1, 0);
        next_cyc(); drive(0, 0, 0, 0, 0);
        next_cyc(); drive(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("halt_en", {27'd0, stage_en},    32'h00);
        chk("halt_fl", {27'd0, stage_flush}, 32'h00);
        next_cyc();
        @(negedge clk);
        chk("halt2_en",   {27'd0, stage_en}, 32'h00);
        chk("halt2_busy", {31'd0, busy}, 32'd1);
        next_cyc(); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_halt_hold", {27'd0, stage_en}, 32'h18);
        next_cyc();
        @(negedge clk);
        chk("post_halt_rel",  {27'd0, stage_en}, 32'h1F);
        next_cyc();
        @(negedge clk);
        chk("halt_stall", {16'd0, stall_cycles}, 32'd7);
        chk("halt_busy",  {31'd0, busy}, 32'd0);

        // Saturation: 70000 load-use stall cycles
        next_cyc(); drive(0, 0, 0, 0, 1);
        repeat (70000) next_cyc();
        @(negedge clk);
        chk("sat_stall", {16'd0, stall_cycles}, 32'hFFFF);
        next_cyc();
        @(negedge clk);
        chk("sat_hold", {16'd0, stall_cycles}, 32'hFFFF);

        // Reset during a vector op with the counter saturated
        next_cyc(); drive(0, 0, 0, 1, 0);
        next_cyc(); drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_vec_en", {27'd0, stage_en},    32'h1F);
        chk("rst_vec_fl", {27'd0, stage_flush}, 32'h1F);
        next_cyc(); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_vec_busy",  {31'd0, busy}, 32'd0);
        chk("rst_vec_stall", {16'd0, stall_cycles}, 32'd0);
        chk("rst_vec_en2",   {27'd0, stage_en}, 32'h1F);
        repeat (VEC_LAT) next_cyc();
        @(negedge clk);
        chk("rst_idle_stall", {16'd0, stall_cycles}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
